// File: rtl/axi4_burst_master.sv
// Single-ID INCR burst AXI4 master behind a valid/ready command port.
// Optional B/R watchdog is compiled in when AXI4_MASTER_TIMEOUT_EN is defined.

module axi4_burst_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [7:0]              beat_cnt_q;
    logic [1:0]              err_q;
    logic [1:0]              err_beat;
    logic                    done_q;
    logic [1:0]              done_resp_q;
    logic                    cmd_hs, w_hs, b_hs, r_hs;
    logic                    last_beat;
    logic                    timeout;

    assign cmd_hs    = (state_q == StIdle) && cmd_valid;
    assign w_hs      = WVALID && WREADY;
    assign b_hs      = BREADY && BVALID;
    assign r_hs      = RVALID && RREADY;
    assign last_beat = (beat_cnt_q == len_q);

`ifdef AXI4_MASTER_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        waiting;

    assign waiting = (state_q == StB) || (state_q == StR);
    assign timeout = waiting && (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK) begin
        if (ARESET || !waiting || b_hs || r_hs) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Running worst response including the beat being accepted now.
    always_comb begin
        err_beat = (RRESP > err_q) ? RRESP : err_q;
        if (RLAST != last_beat) begin
            err_beat = 2'b10;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid) state_d = cmd_write ? StAw : StAr;
            StAw:   if (AWREADY) state_d = StW;
            StW:    if (w_hs && last_beat) state_d = StB;
            StB:    if (b_hs || timeout) state_d = StIdle;
            StAr:   if (ARREADY) state_d = StR;
            StR:    if ((r_hs && last_beat) || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        AWVALID   = 1'b0;
        ARVALID   = 1'b0;
        WVALID    = 1'b0;
        wr_ready  = 1'b0;
        WDATA     = '0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        rd_valid  = 1'b0;
        RREADY    = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StAw:   AWVALID = 1'b1;
            StW: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WDATA    = wr_data;
                WLAST    = last_beat;
            end
            StB:    BREADY = !timeout;
            StAr:   ARVALID = 1'b1;
            StR: begin
                rd_valid = RVALID;
                RREADY   = rd_ready && !timeout;
                rd_data  = RDATA;
                rd_last  = last_beat;
            end
            default: ;
        endcase
    end

    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign done_resp = done_resp_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            beat_cnt_q  <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (cmd_hs) begin
                addr_q     <= cmd_addr;
                len_q      <= cmd_len;
                size_q     <= cmd_size;
                beat_cnt_q <= '0;
                err_q      <= '0;
            end
            if (w_hs || r_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if (r_hs) begin
                err_q <= err_beat;
            end
            if (b_hs) begin
                done_q      <= 1'b1;
                done_resp_q <= BRESP;
            end
            if (r_hs && last_beat) begin
                done_q      <= 1'b1;
                done_resp_q <= err_beat;
            end
            if (timeout) begin
                done_q      <= 1'b1;
                done_resp_q <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master: stimulus pushes expectations, negedge monitors pop them.

module tb_axi4_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, busy;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [31:0] WDATA, RDATA;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY;
    logic        RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi4_burst_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .busy(busy),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } req_t;

    req_t        aw_q[$], ar_q[$];
    logic [32:0] w_q[$], rd_q[$];
    logic [1:0]  done_q[$];
    req_t        aw_e, ar_e;
    logic [32:0] w_e, rd_e;
    logic [1:0]  d_e;

    logic [31:0] wdat [256];
    logic [31:0] rdat [256];
    logic [1:0]  rresp_a [256];
    logic        rlast_a [256];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Monitors sample mid-cycle; handshakes seen here complete on the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (AWVALID && AWREADY) begin
                if (aw_q.size() == 0) fail("aw_unexpected");
                else begin
                    aw_e = aw_q.pop_front();
                    check("awaddr", 64'(AWADDR), 64'(aw_e.addr));
                    check("awlen", 64'(AWLEN), 64'(aw_e.len));
                    check("awsize", 64'(AWSIZE), 64'(aw_e.size));
                end
            end
            if (ARVALID && ARREADY) begin
                if (ar_q.size() == 0) fail("ar_unexpected");
                else begin
                    ar_e = ar_q.pop_front();
                    check("araddr", 64'(ARADDR), 64'(ar_e.addr));
                    check("arlen", 64'(ARLEN), 64'(ar_e.len));
                    check("arsize", 64'(ARSIZE), 64'(ar_e.size));
                end
            end
            if (WVALID && WREADY) begin
                if (w_q.size() == 0) fail("w_unexpected");
                else begin
                    w_e = w_q.pop_front();
                    check("w_last_data", 64'({WLAST, WDATA}), 64'(w_e));
                end
            end
            if (rd_valid && rd_ready) begin
                if (rd_q.size() == 0) fail("rd_unexpected");
                else begin
                    rd_e = rd_q.pop_front();
                    check("rd_last_data", 64'({rd_last, rd_data}), 64'(rd_e));
                end
            end
            if (done) begin
                if (done_q.size() == 0) fail("done_unexpected");
                else begin
                    d_e = done_q.pop_front();
                    check("done_resp", 64'(done_resp), 64'(d_e));
                    check("cmd_ready_at_done", 64'(cmd_ready), 64'(1));
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
        tick();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        #1 check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 16'h0;
        cmd_len   = 8'h0;
        cmd_size  = 3'h0;
    endtask

    task automatic feed_w(input bit toggle, input int stop_at);
        int idx = 0;
        int cyc = 0;
        while (idx < stop_at && cyc < 1000) begin
            tick();
            wr_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            wr_data  = wdat[idx];
            #1;
            if (wr_valid && wr_ready) idx++;
            cyc++;
        end
        if (idx < stop_at) fail("w_stream_stalled");
    endtask

    task automatic b_phase(input logic [1:0] bresp);
        int n = 0;
        BVALID = 1'b1;
        BRESP  = bresp;
        #1;
        while (!BREADY && n < 50) begin
            tick();
            n++;
        end
        if (!BREADY) fail("b_wait");
        tick();
        BVALID = 1'b0;
        BRESP  = 2'b00;
        tick();
    endtask

    task automatic do_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] bresp, input bit toggle, input int aw_wait);
        aw_q.push_back('{addr: addr, len: 8'(len), size: size});
        for (int i = 0; i <= len; i++) w_q.push_back({(i == len), wdat[i]});
        done_q.push_back(bresp);
        AWREADY = (aw_wait == 0);
        send_cmd(1'b1, addr, 8'(len), size);
        for (int i = 0; i < aw_wait; i++) begin
            #1;
            check("awvalid_held", 64'(AWVALID), 64'(1));
            check("awaddr_stable", 64'(AWADDR), 64'(addr));
            tick();
        end
        AWREADY = 1'b1;
        feed_w(toggle, len + 1);
        tick();
        wr_valid = 1'b0;
        b_phase(bresp);
    endtask

    task automatic do_read(input logic [15:0] addr, input int len, input logic [2:0] size,
                           input int stall_at, input int stall_n, input logic [1:0] exp_resp);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        ar_q.push_back('{addr: addr, len: 8'(len), size: size});
        for (int i = 0; i <= len; i++) rd_q.push_back({(i == len), rdat[i]});
        done_q.push_back(exp_resp);
        send_cmd(1'b0, addr, 8'(len), size);
        while (idx <= len && cyc < 1000) begin
            tick();
            RVALID   = 1'b1;
            RDATA    = rdat[idx];
            RRESP    = rresp_a[idx];
            RLAST    = rlast_a[idx];
            rd_ready = !(idx == stall_at && stalled < stall_n);
            #1;
            if (!rd_ready) begin
                check("rready_stall", 64'(RREADY), 64'(0));
                stalled++;
            end
            if (RVALID && RREADY) idx++;
            cyc++;
        end
        if (idx <= len) fail("r_stream_stalled");
        tick();
        RVALID   = 1'b0;
        RLAST    = 1'b0;
        RRESP    = 2'b00;
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic fill_read(input int len, input int seed);
        for (int i = 0; i < 256; i++) begin
            rdat[i]    = 32'(i) ^ 32'(seed);
            rresp_a[i] = 2'b00;
            rlast_a[i] = (i == len);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        AWREADY = 1'b1; ARREADY = 1'b1; WREADY = 1'b1;
        BVALID = 1'b0; BRESP = '0;
        RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_done_resp", 64'(done_resp), 64'(0));
        check("rst_valids", 64'({AWVALID, ARVALID, WVALID, rd_valid}), 64'(0));
        check("rst_readys", 64'({BREADY, RREADY, wr_ready}), 64'(0));
        check("rst_awaddr", 64'(AWADDR), 64'(0));
        ARESET = 1'b0;

        // Single-beat write
        wdat[0] = 32'hA5A5_A5A5;
        do_write(16'h0010, 0, 3'd2, 2'b00, 1'b0, 0);

        // Four-beat write with wr_valid toggling and a slow AWREADY
        wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222;
        wdat[2] = 32'h3333_3333; wdat[3] = 32'h4444_4444;
        do_write(16'h0200, 3, 3'd2, 2'b00, 1'b1, 2);

        // Four-beat read with a two-cycle rd_ready stall on beat 3
        fill_read(3, 32'hC0DE_0000);
        do_read(16'h0100, 3, 3'd2, 2, 2, 2'b00);

        // Write with SLVERR response
        wdat[0] = 32'h0BAD_0001; wdat[1] = 32'h0BAD_0002;
        do_write(16'h0400, 1, 3'd1, 2'b10, 1'b0, 0);

        // Read with SLVERR on beat 2 of 4
        fill_read(3, 32'h5A5A_0000);
        rresp_a[1] = 2'b10;
        do_read(16'h0500, 3, 3'd2, 999, 0, 2'b10);

        // Worst response is the maximum across beats
        fill_read(1, 32'h7777_0000);
        rresp_a[0] = 2'b11; rresp_a[1] = 2'b01;
        do_read(16'h0600, 1, 3'd0, 999, 0, 2'b11);

        // RLAST missing on the counted last beat forces SLVERR
        fill_read(0, 32'h1234_0000);
        rlast_a[0] = 1'b0;
        do_read(16'h0700, 0, 3'd2, 999, 0, 2'b10);

        // Longest burst: 256 beats, rd_last only on the final one
        fill_read(255, 32'hBEEF_0000);
        do_read(16'h0800, 255, 3'd2, 999, 0, 2'b00);

        // Reset during beat 2 of an eight-beat write aborts with no done
        for (int i = 0; i < 8; i++) wdat[i] = 32'hF000_0000 + 32'(i);
        aw_q.push_back('{addr: 16'h0300, len: 8'd7, size: 3'd2});
        w_q.push_back({1'b0, wdat[0]});
        w_q.push_back({1'b0, wdat[1]});
        send_cmd(1'b1, 16'h0300, 8'd7, 3'd2);
        feed_w(1'b0, 2);
        tick();
        ARESET  = 1'b1;
        wr_data = wdat[2];
        tick();
        #1;
        check("abort_valids", 64'({AWVALID, ARVALID, WVALID, rd_valid}), 64'(0));
        check("abort_readys", 64'({BREADY, RREADY, wr_ready}), 64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        ARESET   = 1'b0;
        wr_valid = 1'b0;
        repeat (4) tick();

`ifdef AXI4_MASTER_TIMEOUT_EN
        // BVALID never arrives: watchdog ends the burst with DECERR after 16 cycles in B
        begin
            int n = 0;
            wdat[0] = 32'hDEAD_BEEF;
            aw_q.push_back('{addr: 16'h0900, len: 8'd0, size: 3'd2});
            w_q.push_back({1'b1, wdat[0]});
            done_q.push_back(2'b11);
            send_cmd(1'b1, 16'h0900, 8'd0, 3'd2);
            feed_w(1'b0, 1);
            wr_valid = 1'b0;
            while (!done && n < 100) begin
                tick();
                n++;
            end
            if (!done) fail("timeout_done");
            else check("timeout_cycles_in_b", 64'(n - 1), 64'(16));
            repeat (3) tick();
        end
`endif

        repeat (5) tick();
        check("aw_q_empty", 64'(aw_q.size()), 64'(0));
        check("ar_q_empty", 64'(ar_q.size()), 64'(0));
        check("w_q_empty", 64'(w_q.size()), 64'(0));
        check("rd_q_empty", 64'(rd_q.size()), 64'(0));
        check("done_q_empty", 64'(done_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
